joy_db15_tx: RTL and testbench

//  Responder end of the DB15 serial joystick link. Emulates the adapter's 2x12-bit 74HC165 parallel-in/serial-out chain.

---
 rtl/joy_db15_tx.sv | 157 +++++++++++++++
 tb/tb_joy_db15_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/joy_db15_tx.sv
// joy_db15_tx - responder end of the DB15 serial joystick link.
//
// Emulates the adapter's 2 x NBITS 74HC165 parallel-in/serial-out chain.
// While joy_load is low the two player words are continuously snapshotted
// (inverted, since the line is active-low). After joy_load rises, each rising
// joy_clk shifts the next bit onto joy_data, player 1 bit 0 first.
// joy_load and joy_clk are asynchronous to clk and are synchronised before use.
//
// Ports:
//   clk        system clock (>= 4x joy_clk toggle rate)
//   reset_n    asynchronous active-low reset
//   joystick1  player 1 buttons, active-high
//   joystick2  player 2 buttons, active-high
//   joy_load   active-low parallel load from the receiver
//   joy_clk    shift clock from the receiver
//   joy_data   serial data, active-low (0 = pressed)
//   busy       high while a loaded frame is still being shifted
//   frame_cnt  completed-frame counter (JOY_DB15_TX_STATS_EN only)
//   overrun    sticky: shift clock seen after the frame ended (JOY_DB15_TX_STATS_EN only)
//
// Optional build macro: JOY_DB15_TX_STATS_EN adds frame_cnt/overrun.

module joy_db15_tx #(
    parameter int NBITS       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NBITS-1:0] joystick1,
    input  logic [NBITS-1:0] joystick2,
    input  logic             joy_load,
    input  logic             joy_clk,
    output logic             joy_data,
    output logic             busy
`ifdef JOY_DB15_TX_STATS_EN
    ,
    output logic [7:0]       frame_cnt,
    output logic             overrun
`endif
);

    localparam int FW = 2 * NBITS;
    localparam int CW = $clog2(FW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [FW-1:0]          shreg_q, shreg_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   joy_data_q, joy_data_d;
    logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    logic load_s;
    logic clk_rise;

    always_comb begin
        load_sync_d = {load_sync_q[SYNC_STAGES-2:0], joy_load};
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
        load_s      = load_sync_q[SYNC_STAGES-1];
        clk_rise    = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        joy_data_d = joy_data_q;

        if (!load_s) begin
            // Load has priority over a coincident shift edge in every state.
            state_d    = IDLE;
            shreg_d    = ~{joystick2, joystick1};
            bit_cnt_d  = '0;
            joy_data_d = ~joystick1[0];
        end else begin
            case (state_q)
                IDLE: state_d = SHIFT;
                SHIFT: begin
                    if (clk_rise) begin
                        shreg_d    = {1'b1, shreg_q[FW-1:1]};
                        joy_data_d = shreg_q[1];
                        bit_cnt_d  = bit_cnt_q + CW'(1);
                        // Last real bit has just been shifted off.
                        if (bit_cnt_q == CW'(FW - 1)) state_d = DONE;
                    end
                end
                DONE: begin
                    if (clk_rise) begin
                        shreg_d    = {1'b1, shreg_q[FW-1:1]};
                        joy_data_d = shreg_q[1];
                        bit_cnt_d  = CW'(FW);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '1;
            bit_cnt_q   <= '0;
            joy_data_q  <= 1'b1;
            // Sync chains reset to the inactive line levels.
            load_sync_q <= '1;
            clk_sync_q  <= '0;
            clk_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            joy_data_q  <= joy_data_d;
            load_sync_q <= load_sync_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign joy_data = joy_data_q;
    assign busy     = (state_q == SHIFT);

`ifdef JOY_DB15_TX_STATS_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       overrun_q, overrun_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        if (load_s && clk_rise) begin
            if (state_q == SHIFT && bit_cnt_q == CW'(FW - 1)) frame_cnt_d = frame_cnt_q + 8'd1;
            if (state_q == DONE) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= 8'd0;
            overrun_q   <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_joy_db15_tx.sv
module tb_joy_db15_tx;

    localparam int NBITS = 12;
    localparam int FW    = 2 * NBITS;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NBITS-1:0] joystick1, joystick2;
    logic             joy_load, joy_clk;
    logic             joy_data, busy;
`ifdef JOY_DB15_TX_STATS_EN
    logic [7:0]       frame_cnt;
    logic             overrun;
`endif

    int vecs = 0;
    int errs = 0;
    logic [FW-1:0] frame;

    joy_db15_tx #(.NBITS(NBITS), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .joy_load  (joy_load),
        .joy_clk   (joy_clk),
        .joy_data  (joy_data),
        .busy      (busy)
`ifdef JOY_DB15_TX_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One joy_clk pulse, 4 clk high and 4 clk low; data has settled on return.
    task automatic jclk_edge();
        @(negedge clk) joy_clk = 1'b1;
        repeat (4) @(negedge clk);
        joy_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Load pulse; snapshots the current buttons into the bench's frame model.
    task automatic load_pulse();
        @(negedge clk) joy_load = 1'b0;
        repeat (6) @(negedge clk);
        frame    = ~{joystick2, joystick1};
        joy_load = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Check bits [from, to) against the frame model, one edge per bit.
    task automatic shift_check(input string tag, input int from, input int to);
        for (int k = from; k < to; k++) begin
            chk($sformatf("%s_bit%0d", tag, k), joy_data, (k < FW) ? frame[k] : 1'b1);
            jclk_edge();
            chk($sformatf("%s_busy%0d", tag, k), busy, (k < FW - 1) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        joy_load  = 1'b1;
        joy_clk   = 1'b0;
        joystick1 = 12'h000;
        joystick2 = 12'h000;
        frame     = '1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data", joy_data, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", dut.bit_cnt_q, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_data", joy_data, 1'b1);

        // Full frame: only P1 bit0 and P2 bit11 pressed
        joystick1 = 12'h001;
        joystick2 = 12'h800;
        load_pulse();
        chk("f1_busy_start", busy, 1'b1);
        shift_check("f1", 0, FW);
        chk("f1_after_data", joy_data, 1'b1);

        // Coherence: buttons change mid-frame, snapshot must hold
        joystick1 = 12'h00F;
        joystick2 = 12'h000;
        load_pulse();
        shift_check("coh", 0, 4);
        joystick1 = 12'h000;
        shift_check("coh", 4, FW);
        load_pulse();
        shift_check("coh_new", 0, 4);

        // Abort mid-frame
        joystick1 = 12'h5A5;
        joystick2 = 12'h3C3;
        load_pulse();
        shift_check("abt", 0, 5);
        chk("abt_pre", joy_data, 1'b0);        // ~bit5 of 5A5
        joystick1 = 12'h5A4;
        @(negedge clk) joy_load = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("abt_lat2", joy_data, 1'b0);    // not yet reloaded
        @(posedge clk);
        #1 chk("abt_lat3", joy_data, 1'b1);    // ~5A4[0]
        chk("abt_busy", busy, 1'b0);
        chk("abt_cnt", dut.bit_cnt_q, 0);
        repeat (4) @(negedge clk);
        frame    = ~{joystick2, joystick1};
        joy_load = 1'b1;
        repeat (6) @(negedge clk);
        shift_check("abt_full", 0, FW);

`ifdef JOY_DB15_TX_STATS_EN
        chk("st_frames3", frame_cnt, 3);
        chk("st_ovr0", overrun, 0);
`endif

        // Collision: load fall and clk rise synchronised together
        joystick1 = 12'h002;
        joystick2 = 12'h000;
        load_pulse();
        shift_check("col", 0, 2);
        @(negedge clk);
        joy_load = 1'b0;
        joy_clk  = 1'b1;
        repeat (6) @(negedge clk);
        chk("col_data", joy_data, 1'b1);       // ~002[0], not shifted
        chk("col_cnt", dut.bit_cnt_q, 0);
        joy_clk = 1'b0;
        repeat (4) @(negedge clk);
        joy_load = 1'b1;
        repeat (6) @(negedge clk);
        jclk_edge();
        chk("col_bit1", joy_data, 1'b0);       // ~002[1]
        chk("col_cnt1", dut.bit_cnt_q, 1);

        // Overrun: 25 edges in one frame
        joystick1 = 12'h801;
        joystick2 = 12'h001;
        load_pulse();
        shift_check("ovr", 0, FW + 1);
        chk("ovr_data", joy_data, 1'b1);
        chk("ovr_cnt_sat", dut.bit_cnt_q, FW);
`ifdef JOY_DB15_TX_STATS_EN
        chk("st_frames4", frame_cnt, 4);
        chk("st_ovr1", overrun, 1);
`endif

        // Asynchronous reset mid-frame
        joystick1 = 12'h008;
        load_pulse();
        shift_check("ar", 0, 3);
        chk("ar_pre", joy_data, 1'b0);         // ~008[3]
        @(negedge clk) reset_n = 1'b0;
        #1;
        chk("ar_data", joy_data, 1'b1);
        chk("ar_busy", busy, 1'b0);
        chk("ar_cnt", dut.bit_cnt_q, 0);
`ifdef JOY_DB15_TX_STATS_EN
        chk("ar_frames", frame_cnt, 0);
        chk("ar_ovr", overrun, 0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
